// File: rtl/bus_ram_if.sv
// Control and address side of the shared CPU bus as seen by bus_ram.
// bus_data stays a plain inout on bus_ram so the tristate net resolves in one place.
interface bus_ram_if;
  logic [63:0] bus_addr;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic        ram_rdy;
  logic        ram_err;

  modport master (
    output bus_addr, ram_cs, ram_we, ram_oe,
    input  ram_rdy, ram_err
  );

  modport slave (
    input  bus_addr, ram_cs, ram_we, ram_oe,
    output ram_rdy, ram_err
  );
endinterface

// File: rtl/bus_ram.sv
// bus_ram: 64-bit-word memory responder on the shared CPU bus with programmable
// wait states and a registered ready strobe. One request per trip through IDLE.
// Optional feature macro: BUS_RAM_ERR_EN enables the sticky ram_err flag for
// out-of-range or misaligned accepted requests; undefined ties ram_err to 0.
module bus_ram #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [63:0] ADDR_BASE   = 64'h0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  bus_ram_if.slave    bus,
  inout  wire  [63:0] bus_data
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]  WS_INIT = (WAIT_STATES != 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_range_q, in_range_d;
  logic              wr_q, wr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              rdy_q, rdy_d;

  logic [63:0]       mem_q [DEPTH];

  logic [60:0]       word_c;
  logic              hit_c;
  logic              req_c;
  logic              mem_we_c;
  logic              drive_c;
  logic [63:0]       rdata_c;

  // Word decode of the incoming byte address and request detection
  always_comb begin
    word_c = 61'((bus.bus_addr - ADDR_BASE) >> 3);
    hit_c  = (bus.bus_addr >= ADDR_BASE) && (word_c < 61'(DEPTH));
    req_c  = bus.ram_cs && (bus.ram_we || bus.ram_oe);
  end

  // Next-state, request latching and write-commit decision
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          idx_d      = word_c[IDX_W-1:0];
          in_range_d = hit_c;
          wr_d       = bus.ram_we;
          wdata_d    = bus_data;
          if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.ram_cs) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (!bus.ram_cs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A write lands on the edge that enters RESP, so any later read sees it
    mem_we_c = (state_d == ST_RESP) && (state_q != ST_RESP) && wr_d && in_range_d;
    rdy_d    = (state_q == ST_RESP) && bus.ram_cs;
  end

  // State and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 64'h0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      rdy_q      <= rdy_d;
    end
  end

  // Storage array; contents survive reset, but reset discards a pending commit
  always_ff @(posedge clk) begin
    if (!reset && mem_we_c) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  // Read data drives the bus only in RESP for a pure read
  always_comb begin
    rdata_c = in_range_q ? mem_q[idx_q] : 64'h0;
    drive_c = (state_q == ST_RESP) && bus.ram_cs && bus.ram_oe && !bus.ram_we;
  end

  assign bus_data    = drive_c ? rdata_c : {64{1'bz}};
  assign bus.ram_rdy = rdy_q;

`ifdef BUS_RAM_ERR_EN
  logic err_q, err_d;

  // Sticky error on acceptance of an out-of-range or misaligned request
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && req_c && (!hit_c || (bus.bus_addr[2:0] != 3'd0))) begin
      err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.ram_err = err_q;
`else
  assign bus.ram_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_ram.sv
// Three bus_ram instances (0, 1 and 3 wait states) driven by the same request
// stream and compared every cycle against a transaction-level model.
module tb_bus_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] addr;
  logic        cs, we, oe;
  logic [63:0] tb_wd;
  logic        tb_drv;

  wire  [63:0] bd0, bd1, bd2;

  bus_ram_if if0 ();
  bus_ram_if if1 ();
  bus_ram_if if2 ();

  assign if0.bus_addr = addr; assign if0.ram_cs = cs; assign if0.ram_we = we; assign if0.ram_oe = oe;
  assign if1.bus_addr = addr; assign if1.ram_cs = cs; assign if1.ram_we = we; assign if1.ram_oe = oe;
  assign if2.bus_addr = addr; assign if2.ram_cs = cs; assign if2.ram_we = we; assign if2.ram_oe = oe;

  assign bd0 = tb_drv ? tb_wd : {64{1'bz}};
  assign bd1 = tb_drv ? tb_wd : {64{1'bz}};
  assign bd2 = tb_drv ? tb_wd : {64{1'bz}};

  bus_ram #(.WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .bus(if0), .bus_data(bd0));
  bus_ram #(.WAIT_STATES(1)) u_ws1 (.clk(clk), .reset(reset), .bus(if1), .bus_data(bd1));
  bus_ram #(.WAIT_STATES(3)) u_ws3 (.clk(clk), .reset(reset), .bus(if2), .bus_data(bd2));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state and per-cycle expectations
  logic [63:0] mem_m [3][256];
  bit          err_m [3];
  bit          chk_en = 1'b0;
  logic        exp_rdy [3];
  logic        exp_drv [3];
  logic        exp_err [3];
  logic [63:0] exp_val [3];
  int          seen_k  [3];
  logic [63:0] seen_d  [3];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  function automatic logic rdy_of(input int d);
    return (d == 0) ? if0.ram_rdy : (d == 1) ? if1.ram_rdy : if2.ram_rdy;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? if0.ram_err : (d == 1) ? if1.ram_err : if2.ram_err;
  endfunction

  function automatic logic [63:0] bus_of(input int d);
    return (d == 0) ? bd0 : (d == 1) ? bd1 : bd2;
  endfunction

  function automatic bit in_rng(input logic [63:0] a);
    return (a >> 3) < 64'd256;
  endfunction

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        logic [63:0] b;
        bit ok;
        b = bus_of(d);
        checks++;
        if (rdy_of(d) !== exp_rdy[d]) begin
          errors++;
          $display("FAIL rdy dut%0d t=%0t: got %b expected %b", d, $time, rdy_of(d), exp_rdy[d]);
        end
        checks++;
        if (err_of(d) !== exp_err[d]) begin
          errors++;
          $display("FAIL err dut%0d t=%0t: got %b expected %b", d, $time, err_of(d), exp_err[d]);
        end
        checks++;
        if (exp_drv[d])   ok = (b === exp_val[d]);
        else if (tb_drv)  ok = (b === tb_wd);
        else              ok = $isunknown(b) || (b === 64'h0);
        if (!ok) begin
          errors++;
          $display("FAIL bus dut%0d t=%0t: got %h expected %s %h", d, $time, b,
                   exp_drv[d] ? "read" : (tb_drv ? "tb-data" : "float"),
                   exp_drv[d] ? exp_val[d] : tb_wd);
        end
      end
    end
  end

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_idle_exp();
    for (int d = 0; d < 3; d++) begin
      exp_rdy[d] = 1'b0;
      exp_drv[d] = 1'b0;
      exp_err[d] = err_m[d];
      exp_val[d] = 64'h0;
    end
  endtask

  task automatic idle(input int n);
    cs = 1'b0; we = 1'b0; oe = 1'b0; tb_drv = 1'b0;
    set_idle_exp();
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One request: cs held for h edges starting at the acceptance edge a.
  // r > 0 asserts reset on edge a+r (caller uses h = r+1).
  task automatic do_txn(input logic [63:0] a_addr, input bit a_we, input bit a_oe,
                        input logic [63:0] a_wd, input int h, input int r);
    addr = a_addr; we = a_we; oe = a_oe; cs = 1'b1; tb_wd = a_wd; tb_drv = a_we;
    set_idle_exp();
    @(posedge clk); #1;
`ifdef BUS_RAM_ERR_EN
    if (!in_rng(a_addr) || (a_addr[2:0] != 3'd0))
      for (int d = 0; d < 3; d++) err_m[d] = 1'b1;
`endif
    for (int d = 0; d < 3; d++) begin
      seen_k[d] = -1;
      seen_d[d] = 64'h0;
    end
    for (int k = 0; k <= h; k++) begin
      cs    = (k + 1 < h);
      reset = (r > 0) && (k + 1 == r);
      for (int d = 0; d < 3; d++) begin
        int  w;
        bit  live;
        w    = ws_of(d);
        live = (r == 0) || (k < r);
        if (r > 0 && k == r) err_m[d] = 1'b0;
        if (a_we && live && k == w && w <= h - 1 && in_rng(a_addr))
          mem_m[d][a_addr[10:3]] = a_wd;
        exp_rdy[d] = live && (k >= w + 1) && (k <= h - 1);
        exp_drv[d] = live && (k >= w) && (k <= h - 1) && cs && a_oe && !a_we;
        exp_val[d] = in_rng(a_addr) ? mem_m[d][a_addr[10:3]] : 64'h0;
        exp_err[d] = err_m[d];
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (seen_k[d] < 0 && rdy_of(d) === 1'b1) begin
          seen_k[d] = k;
          seen_d[d] = bus_of(d);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    idle(0);
  endtask

  localparam logic [63:0] PRE  = 64'hC0DE_0000_0000_0000;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] NEW4 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] BAD8 = 64'h0BAD_F00D_0000_0008;

  initial begin
    for (int d = 0; d < 3; d++) begin
      err_m[d] = 1'b0;
      for (int i = 0; i < 256; i++) mem_m[d][i] = 64'h0;
    end
    reset = 1'b1; cs = 1'b0; we = 1'b0; oe = 1'b0; addr = 64'h0; tb_wd = 64'h0; tb_drv = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    // Preload words 0..15 on every instance
    for (int i = 0; i < 16; i++) do_txn(64'(i * 8), 1'b1, 1'b0, PRE + 64'(i), 5, 0);

    // Write then read back at 0x10, latency per wait-state setting
    do_txn(64'h10, 1'b1, 1'b0, DEAD, 5, 0);
    do_txn(64'h10, 1'b0, 1'b1, 64'h0, 6, 0);
    chk_int("lat_ws0", seen_k[0], 1);
    chk_int("lat_ws1", seen_k[1], 2);
    chk_int("lat_ws3", seen_k[2], 4);
    chk64("rd10_ws1", seen_d[1], DEAD);
    chk64("rd10_ws3", seen_d[2], DEAD);

    // Read of preloaded word 0 with no wait states
    do_txn(64'h0, 1'b0, 1'b1, 64'h0, 6, 0);
    chk64("rd0_ws0", seen_d[0], PRE);

    // Short write to 0x20: 3-wait-state instance aborts in WAIT
    do_txn(64'h20, 1'b1, 1'b0, NEW4, 3, 0);
    chk_int("abort_no_rdy", seen_k[2], -1);
    do_txn(64'h20, 1'b0, 1'b1, 64'h0, 6, 0);
    chk64("rd20_ws3_old", seen_d[2], PRE + 64'd4);
    chk64("rd20_ws1_new", seen_d[1], NEW4);

    // we and oe together act as a write
    do_txn(64'h8, 1'b1, 1'b1, BAD8, 6, 0);
    do_txn(64'h8, 1'b0, 1'b1, 64'h0, 6, 0);
    chk64("weoe_write", seen_d[1], BAD8);

    // Out of range read, then misaligned read of word 2
    do_txn(64'h800, 1'b0, 1'b1, 64'h0, 6, 0);
    chk_int("oor_lat", seen_k[1], 2);
    chk64("oor_data", seen_d[1], 64'h0);
    do_txn(64'h13, 1'b0, 1'b1, 64'h0, 6, 0);
    chk64("misalign_data", seen_d[1], DEAD);
`ifdef BUS_RAM_ERR_EN
    chk64("err_sticky", 64'(if1.ram_err), 64'h1);
`else
    chk64("err_tied", 64'(if1.ram_err), 64'h0);
`endif

    // Reset while the zero-wait instance sits in RESP; contents retained
    do_txn(64'h18, 1'b0, 1'b1, 64'h0, 3, 2);
    chk_int("rst_rdy_seen", seen_k[0], 1);
    do_txn(64'h18, 1'b0, 1'b1, 64'h0, 6, 0);
    chk64("rst_retained", seen_d[0], PRE + 64'd3);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [63:0] a;
      logic [63:0] wd;
      int sel, op, h, r;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 64'($urandom_range(0, 15)) << 3;
      else if (sel == 7) a = (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(1, 7));
      else if (sel == 8) a = 64'h800 + (64'($urandom_range(0, 31)) << 3);
      else               a = {32'hFFFF_0000, $urandom} & ~64'h7;
      op = $urandom_range(0, 2);
      h  = $urandom_range(1, 7);
      r  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      if (r > 0) h = r + 1;
      wd = {$urandom, $urandom} | 64'h1;
      do_txn(a, op != 0, op != 1, wd, h, r);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
